// File: rtl/if_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_queue_pkg
// Shared constants for the instruction-fetch queue slice of the RV32 core.
//   INST_W : instruction width (32)
//   RV_NOP : canonical bubble instruction, addi x0,x0,0
//   `InstCatchDepth : core-wide PC / instruction-memory byte-address width,
//                     reused as the default ADDR_W of the fetch queue
// ----------------------------------------------------------------------------
`ifndef InstCatchDepth
`define InstCatchDepth 32
`endif

package if_fetch_queue_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry queue of {pc, inst} pairs for the fetch stage.
// Ports:
//   clk, rst         clock, synchronous active-high reset (control only)
//   clear            drop all entries (pipeline flush)
//   push, push_pc,   write one entry at the tail
//   push_inst
//   pop              retire the head entry
//   count            number of valid entries (0..DEPTH)
//   head_pc,         raw storage at the read pointer; stale when count==0
//   head_inst
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
`ifndef InstCatchDepth
`define InstCatchDepth 32
`endif

module fetch_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int ADDR_W = `InstCatchDepth,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_pc,
    input  logic [INST_W-1:0]            push_inst,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [ADDR_W-1:0]            head_pc,
    output logic [INST_W-1:0]            head_inst
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            // Power-of-two depth: plain increment wraps modulo DEPTH.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only: never reset, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    assign head_pc   = pc_mem[rd_ptr];
    assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
// Fetch stage between the PC generator and decode. Issues an instruction
// memory read at pc_i, captures the data one cycle later and queues
// {pc, inst} for decode under a valid/ready handshake. Holds the PC
// generator whenever the queue cannot accept another response, and throws
// away every wrong-path fetch when a taken jump (flush_i) arrives.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pc_i            current PC from the PC generator
//   pc_hold_o       PC generator keeps its value while 1
//   flush_i         taken jump / redirect this cycle
//   imem_en_o       instruction-memory read enable
//   imem_addr_o     read address (= pc_i)
//   imem_rdata_i    read data, valid the cycle after imem_en_o
//   id_valid_o      queue head valid to decode
//   id_ready_i      decode accepts the head
//   id_inst_o       head instruction
//   id_pc_o         head PC
// Optional build macro IF_BUBBLE_NOP_EN: when defined, id_inst_o/id_pc_o
// show addi x0,x0,0 / 0 whenever id_valid_o is low; otherwise they show the
// raw storage at the read pointer.
// ----------------------------------------------------------------------------
`ifndef InstCatchDepth
`define InstCatchDepth 32
`endif

module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int ADDR_W = `InstCatchDepth,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_hold_o,
    input  logic              flush_i,
    output logic              imem_en_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [INST_W-1:0] id_inst_o,
    output logic [ADDR_W-1:0] id_pc_o
);

    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [CNT_W-1:0]  count;
    logic              req_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_inst;
    logic              pop;
    logic              push;
    logic [CNT_W:0]    credit;
    logic              can_issue;

    // Head is never handed to decode in a flush cycle: it is wrong-path.
    assign id_valid_o = ~rst & (count != '0) & ~flush_i;
    assign pop        = id_valid_o & id_ready_i;

    // Returning response is dropped if it lands in a flush cycle.
    assign push = req_q & ~flush_i;

    // Occupancy after this cycle, counting the in-flight request as already
    // owning a slot; issuing only below DEPTH means a response always fits.
    assign credit    = {1'b0, count} + {{CNT_W{1'b0}}, req_q} - {{CNT_W{1'b0}}, pop};
    assign can_issue = credit < DEPTH_C;

    // During flush pc_i is wrong-path: no read, and no hold so the PC
    // generator loads the jump target.
    assign imem_en_o   = ~rst & ~flush_i & can_issue;
    assign pc_hold_o   = ~rst & ~flush_i & ~can_issue;
    assign imem_addr_o = pc_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= 1'b0;
            pc_q  <= '0;
        end else begin
            req_q <= imem_en_o;
            if (imem_en_o) pc_q <= pc_i;
        end
    end

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_i),
        .push      (push),
        .push_pc   (pc_q),
        .push_inst (imem_rdata_i),
        .pop       (pop),
        .count     (count),
        .head_pc   (head_pc),
        .head_inst (head_inst)
    );

`ifdef IF_BUBBLE_NOP_EN
    assign id_inst_o = id_valid_o ? head_inst : RV_NOP;
    assign id_pc_o   = id_valid_o ? head_pc   : '0;
`else
    assign id_inst_o = head_inst;
    assign id_pc_o   = head_pc;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_queue
// Bench for if_fetch_queue (ADDR_W=32, DEPTH=2). A PC generator and an
// instruction memory surround the DUT; a queue-level model predicts every
// output each cycle, and directed phases pin key cycles with literal values:
// streaming, backpressure, flush with a full queue, flush coincident with a
// returning response, and reset mid-stream.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_i = 1'b0;
    logic              id_ready_i = 1'b1;
    logic [ADDR_W-1:0] pc_i;
    logic [ADDR_W-1:0] target = '0;
    logic              pc_hold_o;
    logic              imem_en_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_rdata_i = '0;
    logic              id_valid_o;
    logic [31:0]       id_inst_o;
    logic [ADDR_W-1:0] id_pc_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    if_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_hold_o    (pc_hold_o),
        .flush_i      (flush_i),
        .imem_en_o    (imem_en_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_inst_o    (id_inst_o),
        .id_pc_o      (id_pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // PC generator: reset to 0, jump on flush, else advance unless held.
    always @(posedge clk) begin
        if (rst)             pc_i <= '0;
        else if (flush_i)    pc_i <= target;
        else if (!pc_hold_o) pc_i <= pc_i + 32'd4;
    end

    // Instruction memory with one-cycle read latency.
    always @(posedge clk) begin
        if (imem_en_o) imem_rdata_i <= inst_of(imem_addr_o);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- queue-level model + per-cycle compare ----------------
    logic [31:0] mq[$];        // PCs that decode will see, in order
    bit          m_infl;       // a read is outstanding
    logic [31:0] m_infl_pc;
    logic [31:0] acc[$];       // PCs decode actually accepted
    bit          ev, ep, ei;
    int          occ;

    initial begin
        m_infl = 1'b0;
        forever begin
            @(negedge clk);
            ev  = !rst && (mq.size() != 0) && !flush_i;
            ep  = ev && id_ready_i;
            occ = mq.size() + int'(m_infl) - int'(ep);
            ei  = !rst && !flush_i && (occ < DEPTH);

            chk("id_valid", 32'(id_valid_o), 32'(ev));
            chk("imem_en",  32'(imem_en_o),  32'(ei));
            chk("pc_hold",  32'(pc_hold_o),  32'(!rst && !flush_i && !(occ < DEPTH)));
            if (ei) chk("imem_addr", imem_addr_o, pc_i);
            if (ev) begin
                chk("id_pc",   id_pc_o,   mq[0]);
                chk("id_inst", id_inst_o, inst_of(mq[0]));
            end
`ifdef IF_BUBBLE_NOP_EN
            else begin
                chk("bubble_inst", id_inst_o, 32'h0000_0013);
                chk("bubble_pc",   id_pc_o,   32'h0);
            end
`endif
            chk("count_bound", 32'(dut.u_fifo.count <= DEPTH), 32'd1);

            if (id_valid_o && id_ready_i) acc.push_back(id_pc_o);

            if (rst || flush_i) begin
                mq.delete();
                m_infl = 1'b0;
            end else begin
                if (ep) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_infl_pc);
                m_infl    = ei;
                m_infl_pc = pc_i;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic r, input logic f, input logic rdy);
        @(posedge clk);
        #1;
        rst        = r;
        flush_i    = f;
        id_ready_i = rdy;
        @(negedge clk);
        #1;
    endtask

    logic [31:0] exp_acc [18] = '{
        32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
        32'h24, 32'h40, 32'h44, 32'h48, 32'h80, 32'h84, 32'h00, 32'h04, 32'h08
    };

    initial begin
        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1);
            chk("rst_valid", 32'(id_valid_o), 32'd0);
            chk("rst_en",    32'(imem_en_o),  32'd0);
            chk("rst_hold",  32'(pc_hold_o),  32'd0);
        end
        chk("rst_count", 32'(dut.u_fifo.count), 32'd0);
        chk("rst_req",   32'(dut.req_q),        32'd0);

        // Stream from 0, stall decode for 6 cycles with 0x10 at the head.
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 1'b0, (k >= 6 && k < 12) ? 1'b0 : 1'b1);
            if (k == 2) begin
                chk("first_valid", 32'(id_valid_o), 32'd1);
                chk("first_pc",    id_pc_o,         32'h00);
            end
            if (k == 3) chk("second_pc", id_pc_o, 32'h04);
            if (k == 6) chk("bp_head", id_pc_o, 32'h10);
            if (k == 8) begin
                chk("bp_hold",  32'(pc_hold_o),         32'd1);
                chk("bp_en",    32'(imem_en_o),         32'd0);
                chk("bp_count", 32'(dut.u_fifo.count),  32'd2);
                chk("bp_head2", id_pc_o,                32'h10);
            end
            if (k == 14) chk("bp_resume", id_pc_o, 32'h18);
        end

        // Fill the queue, then flush to 0x40.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        target = 32'h40;
        step(1'b0, 1'b1, 1'b1);
        chk("fl_count", 32'(dut.u_fifo.count), 32'd2);
        chk("fl_valid", 32'(id_valid_o),       32'd0);
        chk("fl_hold",  32'(pc_hold_o),        32'd0);
        chk("fl_en",    32'(imem_en_o),        32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("fl_p1_valid", 32'(id_valid_o), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("fl_p2_valid", 32'(id_valid_o), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("fl_p3_valid", 32'(id_valid_o), 32'd1);
        chk("fl_p3_pc",    id_pc_o,         32'h40);
        chk("fl_p3_inst",  id_inst_o,       32'hBEAF_0040);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Flush while a response is returning.
        target = 32'h80;
        step(1'b0, 1'b1, 1'b1);
        chk("flr_req",   32'(dut.req_q),        32'd1);
        chk("flr_count", 32'(dut.u_fifo.count), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("flr_cleared", 32'(dut.u_fifo.count), 32'd0);
        chk("flr_valid",   32'(id_valid_o),       32'd0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("flr_pc", id_pc_o, 32'h80);
        step(1'b0, 1'b0, 1'b1);

        // Fill, then reset for one cycle mid-stream.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("mr_count", 32'(dut.u_fifo.count), 32'd2);
        step(1'b1, 1'b0, 1'b1);
        chk("mr_valid", 32'(id_valid_o), 32'd0);
        chk("mr_en",    32'(imem_en_o),  32'd0);
        chk("mr_hold",  32'(pc_hold_o),  32'd0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("mr_first_valid", 32'(id_valid_o), 32'd1);
        chk("mr_first_pc",    id_pc_o,         32'h00);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Everything decode accepted, in order, with no gap or wrong-path PC.
        chk("acc_size", 32'(acc.size()), 32'd18);
        for (int i = 0; i < 18; i++) begin
            if (i < acc.size()) chk($sformatf("acc[%0d]", i), acc[i], exp_acc[i]);
            else                chk($sformatf("acc[%0d]", i), 32'hxxxx_xxxx, exp_acc[i]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
